pp_accum_ctrl: RTL
==================

PP_ACCUM_CTRL -- requirements
Module: pp_accum_ctrl

Interface
REQ-001 Parameter MAX_TERMS, default 16, maximum number of partial-product terms accumulated per transaction (range 2..16).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 clr  input  1  synchronous soft abort; discards any transaction in progress.
REQ-005 in_valid  input  1  partial-product term present.
REQ-006 in_ready  output  1  block accepts a term this cycle.
REQ-007 in_data  input  32  partial-product term (already sign-extended and shifted).
REQ-008 in_neg  input  1  Booth negation correction; used as adder carry-in (+1) for this term.
REQ-009 in_last  input  1  final term of the transaction.
REQ-010 out_valid  output  1  accumulated result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_sum  output  32  accumulated sum, modulo 2^32.
REQ-013 out_carry  output  1  sticky OR of adder carry-out over all terms of the transaction.
REQ-014 out_count  output  5  number of terms accepted in the transaction (1..MAX_TERMS).
REQ-015 out_trunc  output  1  transaction ended by the MAX_TERMS limit, not by in_last.

Function
REQ-016 Term accepted ("beat") iff in_valid && in_ready on a rising edge.
REQ-017 States: IDLE, ACC, DONE; one-hot or binary encoding, implementer's choice.
REQ-018 IDLE: in_ready=1, out_valid=0, accumulator=0, carry flag=0, count=0.
REQ-019 Each beat: acc <= adder(a=acc, b=in_data, ci=in_neg).s; carry flag <= carry flag | adder.co; count <= count+1.
REQ-020 IDLE beat with in_last=0 -> ACC; with in_last=1 -> DONE.
REQ-021 ACC: in_ready=1; beat with in_last=1 -> DONE; else stay ACC.
REQ-022 Beat that brings count to MAX_TERMS with in_last=0 -> DONE with out_trunc=1; with in_last=1, out_trunc=0.
REQ-023 DONE: in_ready=0, out_valid=1; out_sum/out_carry/out_count/out_trunc stable until handshake.
REQ-024 DONE with out_ready=1 -> IDLE next cycle, accumulator and flags cleared; no term is accepted in that cycle.
REQ-025 Latency: out_valid rises the cycle after the last beat; single-term transaction gives out_valid one cycle after its beat.
REQ-026 Throughput: one term per cycle; minimum 2 cycles between transactions (DONE then IDLE).
REQ-027 in_valid=0 in ACC: hold state, no accumulator change.
REQ-028 out_ready while not in DONE: ignored.
REQ-029 clr=1: next state IDLE, all registers cleared, beat in that cycle discarded; clr has priority over every transition.
REQ-030 Arithmetic wraps modulo 2^32; overflow reported only via out_carry.

Reset
REQ-031 rst_n=0 sampled at a rising edge: state IDLE; out_valid=0, out_sum=0, out_carry=0, out_count=0, out_trunc=0; in_ready=1 from the first cycle after reset release.
REQ-032 Reset mid-transaction or in DONE discards the result with no out_valid pulse; rst_n has priority over clr.

Structure
REQ-033 Exactly one instance of the existing adder_32bits performs all additions; no other adder in the block.
REQ-034 State encoding constants and MAX_TERMS default live in shared package pp_accum_pkg.
REQ-035 Adder path combinational from acc register to acc register; no pipeline register inside the accumulate loop.

Verification
REQ-036 Terms 0x00000001, 0x00000002, 0x00000003 (last on third), in_neg=0 -> out_sum=0x00000006, out_carry=0, out_count=3, out_trunc=0, out_valid one cycle after third beat.
REQ-037 Terms 0xFFFFFFFF then 0x00000001 last, in_neg=0 -> out_sum=0x00000000, out_carry=1, out_count=2.
REQ-038 Booth negation: term 0xFFFFFFF0 (~0x0000000F) with in_neg=1, then 0x00000014 last -> out_sum=0x00000005, out_carry=1.
REQ-039 16 terms of 0x00000001, in_last never set -> DONE after 16th beat, out_sum=0x00000010, out_count=16, out_trunc=1, 17th term stalled (in_ready=0).
REQ-040 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE, in_ready=1 the following cycle.
REQ-041 clr after 2 beats, then new single term 0x0000000A last -> out_sum=0x0000000A, out_count=1; same sequence with rst_n=0 instead of clr gives identical result and no stale out_valid.

Source files
------------

// File: rtl/pp_accum_pkg.sv
// pp_accum_pkg: shared state encoding and limits for the partial-product accumulator.
// Contents: state_t (IDLE/ACC/DONE), MAX_TERMS_DEF default term limit, CNT_W count width.
package pp_accum_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    localparam int MAX_TERMS_DEF = 16;
    localparam int CNT_W         = 5;
endpackage

// File: rtl/adder_32bits.sv
// adder_32bits: 32-bit ripple-style adder with carry-in and carry-out.
// Ports: a, b (operands), ci (carry-in) -> s (sum mod 2^32), co (carry-out).
module adder_32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {32'b0, ci};
endmodule

// File: rtl/pp_accum_ctrl.sv
// pp_accum_ctrl: accumulates a stream of partial-product terms into one 32-bit sum per transaction.
// Ports: i_clk, i_rst_n (sync active-low), i_clr (soft abort);
//        input stream i_in_valid/o_in_ready/i_in_data/i_in_neg/i_in_last;
//        result o_out_valid/i_out_ready/o_out_sum/o_out_carry/o_out_count/o_out_trunc.
module pp_accum_ctrl
    import pp_accum_pkg::*;
#(
    parameter int MAX_TERMS = MAX_TERMS_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [31:0]       i_in_data,
    input  logic              i_in_neg,
    input  logic              i_in_last,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [31:0]       o_out_sum,
    output logic              o_out_carry,
    output logic [CNT_W-1:0]  o_out_count,
    output logic              o_out_trunc
);
    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_acc;
    logic               r_carry;
    logic [CNT_W-1:0]   r_count;
    logic               r_trunc;
    logic [31:0]        w_sum;
    logic               w_co;
    logic               w_beat;
    logic               w_limit;
    logic               w_ack;

    adder_32bits u_add (
        .a  (r_acc),
        .b  (i_in_data),
        .ci (i_in_neg),
        .s  (w_sum),
        .co (w_co)
    );

    assign o_in_ready  = (r_state != ST_DONE);
    assign o_out_valid = (r_state == ST_DONE);
    assign o_out_sum   = r_acc;
    assign o_out_carry = r_carry;
    assign o_out_count = r_count;
    assign o_out_trunc = r_trunc;

    always_comb begin
        w_beat  = i_in_valid && o_in_ready;
        // This beat fills the last available slot.
        w_limit = (r_count + CNT_W'(1)) == CNT_W'(MAX_TERMS);
        w_ack   = (r_state == ST_DONE) && i_out_ready;
        w_next  = r_state;
        if (w_beat)
            w_next = (i_in_last || w_limit) ? ST_DONE : ST_ACC;
        if (w_ack)
            w_next = ST_IDLE;
        if (i_clr)
            w_next = ST_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr || w_ack) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_trunc <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_beat) begin
                r_acc   <= w_sum;
                r_carry <= r_carry | w_co;
                r_count <= r_count + CNT_W'(1);
                r_trunc <= w_limit && !i_in_last;
            end
        end
    end
endmodule
